// File: rtl/cache_types.sv
// Shared types and constants for the cache-to-memory burst adaptor.
package cache_types;

    localparam int S_OFFSET = 5;
    localparam int N_BEATS  = 4;

    typedef logic [255:0] line_t;
    typedef logic [63:0]  burst_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns whole-line read/write requests from the cache into 4-beat, 64-bit
// bursts on the main-memory interface and answers with a one-cycle resp.
module cacheline_adaptor
    import cache_types::*;
#(
    parameter int s_offset = S_OFFSET,
    parameter int s_line   = $bits(line_t),
    parameter int s_burst  = $bits(burst_t)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [31:0]        pmem_address,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [s_line-1:0]  pmem_wdata,
    output logic [s_line-1:0]  pmem_rdata,
    output logic               pmem_resp,

    output logic [31:0]        mem_address,
    output logic               mem_read,
    output logic               mem_write,
    output logic [s_burst-1:0] mem_wdata,
    input  logic [s_burst-1:0] mem_rdata,
    input  logic               mem_resp
);

    localparam int n_beats = s_line / s_burst;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);
    localparam logic [1:0]  LAST_BEAT = 2'(n_beats - 1);

    adaptor_state_t state;
    logic [1:0]     cnt;

    // Line buffer viewed as beats; beat 0 is the least-significant 64 bits.
    logic [n_beats-1:0][s_burst-1:0] buffer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pmem_rdata  <= '0;
            pmem_resp   <= 1'b0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Write wins when both are raised; the cache re-requests the read.
                    if (pmem_write) begin
                        buffer      <= pmem_wdata;
                        mem_address <= pmem_address & LINE_MASK;
                        mem_write   <= 1'b1;
                        state       <= WRITE;
                    end else if (pmem_read) begin
                        mem_address <= pmem_address & LINE_MASK;
                        mem_read    <= 1'b1;
                        state       <= READ;
                    end
                end

                READ: begin
                    if (mem_resp) begin
                        buffer[cnt] <= mem_rdata;
                        cnt         <= cnt + 2'd1;
                        if (cnt == LAST_BEAT) begin
                            // Final beat bypasses the buffer so the line is complete on entry to DONE.
                            pmem_rdata <= {mem_rdata, buffer[n_beats-2:0]};
                            pmem_resp  <= 1'b1;
                            mem_read   <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end

                WRITE: begin
                    if (mem_resp) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BEAT) begin
                            pmem_resp <= 1'b1;
                            mem_write <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_wdata = '0;
        if (state == WRITE) begin
            mem_wdata = buffer[cnt];
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, gapped writes, priority,
// back-to-back traffic, mid-burst reset and stray memory responses.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    int checks = 0;
    int errors = 0;

    cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Zero-gap read beats; the request must already be accepted.
    task automatic read_beats(input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] b2, input logic [63:0] b3);
        logic [63:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        for (int i = 0; i < 4; i++) begin
            mem_resp  = 1'b1;
            mem_rdata = beats[i];
            check("rd_resp_low_before_beat", {255'd0, pmem_resp}, 256'd0);
            check("rd_mem_read_held", {255'd0, mem_read}, 256'd1);
            step();
        end
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    localparam logic [63:0] W_A = 64'hA0A0_A0A0_A0A0_A0A0;
    localparam logic [63:0] W_B = 64'hB1B1_B1B1_B1B1_B1B1;
    localparam logic [63:0] W_C = 64'hC2C2_C2C2_C2C2_C2C2;
    localparam logic [63:0] W_D = 64'hD3D3_D3D3_D3D3_D3D3;

    initial begin
        logic [255:0] line1;
        logic [255:0] line2;
        logic [255:0] line3;
        logic [63:0]  wbeats [4];

        line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line2 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        line3 = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        wbeats[0] = W_A; wbeats[1] = W_B; wbeats[2] = W_C; wbeats[3] = W_D;

        rst          = 1'b1;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        mem_rdata    = '0;
        mem_resp     = 1'b0;
        step();
        step();
        check("rst_mem_read", {255'd0, mem_read}, 256'd0);
        check("rst_mem_write", {255'd0, mem_write}, 256'd0);
        check("rst_pmem_resp", {255'd0, pmem_resp}, 256'd0);
        check("rst_pmem_rdata", pmem_rdata, 256'd0);
        check("rst_mem_address", {224'd0, mem_address}, 256'd0);
        check("rst_mem_wdata", {192'd0, mem_wdata}, 256'd0);
        rst = 1'b0;
        step();

        // Zero-gap read: accepted at cycle 0, resp in cycle 5.
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_1234;
        step();
        check("rd1_mem_read", {255'd0, mem_read}, 256'd1);
        check("rd1_mem_write", {255'd0, mem_write}, 256'd0);
        check("rd1_mem_address", {224'd0, mem_address}, {224'd0, 32'h0000_1220});
        pmem_address = 32'hFFFF_FFFF;
        read_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        check("rd1_pmem_resp", {255'd0, pmem_resp}, 256'd1);
        check("rd1_mem_read_drop", {255'd0, mem_read}, 256'd0);
        check("rd1_pmem_rdata", pmem_rdata, line1);
        check("rd1_addr_held", {224'd0, mem_address}, {224'd0, 32'h0000_1220});
        step();
        check("rd1_resp_one_cycle", {255'd0, pmem_resp}, 256'd0);
        check("rd1_done_ignores_req", {255'd0, mem_read}, 256'd0);
        pmem_read = 1'b0;
        step();
        check("rd1_idle_after", {255'd0, mem_read}, 256'd0);

        // Stray memory responses while idle.
        mem_resp  = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        step();
        check("idle_resp_mem_read", {255'd0, mem_read}, 256'd0);
        check("idle_resp_mem_write", {255'd0, mem_write}, 256'd0);
        check("idle_resp_pmem_resp", {255'd0, pmem_resp}, 256'd0);
        check("idle_resp_rdata", pmem_rdata, line1);
        mem_resp  = 1'b0;
        mem_rdata = '0;
        step();

        // Write with two idle cycles before every ack.
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_ABCD;
        pmem_wdata   = {W_D, W_C, W_B, W_A};
        step();
        check("wr_mem_write", {255'd0, mem_write}, 256'd1);
        check("wr_mem_read", {255'd0, mem_read}, 256'd0);
        check("wr_mem_address", {224'd0, mem_address}, {224'd0, 32'h0000_ABC0});
        pmem_wdata   = '1;
        pmem_address = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wr_gap1_wdata", {192'd0, mem_wdata}, {192'd0, wbeats[i]});
            step();
            check("wr_gap2_wdata", {192'd0, mem_wdata}, {192'd0, wbeats[i]});
            check("wr_gap_no_resp", {255'd0, pmem_resp}, 256'd0);
            mem_resp = 1'b1;
            #1;
            check("wr_ack_wdata", {192'd0, mem_wdata}, {192'd0, wbeats[i]});
            step();
            mem_resp = 1'b0;
        end
        check("wr_pmem_resp", {255'd0, pmem_resp}, 256'd1);
        check("wr_mem_write_drop", {255'd0, mem_write}, 256'd0);
        check("wr_rdata_unchanged", pmem_rdata, line1);
        step();
        check("wr_resp_one_cycle", {255'd0, pmem_resp}, 256'd0);

        // Back-to-back: read issued the cycle after the write's resp.
        pmem_write   = 1'b0;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_0040;
        step();
        check("b2b_mem_read", {255'd0, mem_read}, 256'd1);
        check("b2b_mem_write", {255'd0, mem_write}, 256'd0);
        check("b2b_mem_address", {224'd0, mem_address}, {224'd0, 32'h0000_0040});
        check("b2b_rdata_held", pmem_rdata, line1);
        read_beats(64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                   64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888);
        check("b2b_pmem_resp", {255'd0, pmem_resp}, 256'd1);
        check("b2b_pmem_rdata", pmem_rdata, line2);
        step();
        pmem_read = 1'b0;
        step();

        // Read and write together: write is served first.
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0100;
        pmem_wdata   = line3;
        step();
        check("both_mem_write", {255'd0, mem_write}, 256'd1);
        check("both_mem_read", {255'd0, mem_read}, 256'd0);
        check("both_wdata_beat0", {192'd0, mem_wdata}, {192'd0, 64'hAAAA_0000_0000_0001});
        mem_resp = 1'b1;
        step();
        check("both_wdata_beat1", {192'd0, mem_wdata}, {192'd0, 64'hBBBB_0000_0000_0002});
        step();
        step();
        check("both_wdata_beat3", {192'd0, mem_wdata}, {192'd0, 64'hDDDD_0000_0000_0004});
        step();
        mem_resp = 1'b0;
        check("both_pmem_resp", {255'd0, pmem_resp}, 256'd1);
        check("both_rdata_unchanged", pmem_rdata, line2);
        step();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        step();

        // Reset after two beats of a read aborts the burst.
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_2008;
        step();
        mem_resp  = 1'b1;
        mem_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
        step();
        step();
        mem_resp = 1'b0;
        rst      = 1'b1;
        step();
        check("abort_mem_read", {255'd0, mem_read}, 256'd0);
        check("abort_pmem_resp", {255'd0, pmem_resp}, 256'd0);
        check("abort_rdata_cleared", pmem_rdata, 256'd0);
        rst = 1'b0;
        step();
        check("abort_reaccept", {255'd0, mem_read}, 256'd1);
        check("abort_reaccept_addr", {224'd0, mem_address}, {224'd0, 32'h0000_2000});
        check("abort_no_resp", {255'd0, pmem_resp}, 256'd0);
        read_beats(64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002,
                   64'hCCCC_0000_0000_0003, 64'hDDDD_0000_0000_0004);
        check("abort_new_resp", {255'd0, pmem_resp}, 256'd1);
        check("abort_new_rdata", pmem_rdata, line3);
        step();
        pmem_read = 1'b0;
        step();
        check("final_idle", {254'd0, mem_read, mem_write}, 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Responder on the cache's physical-memory port. Accepts whole-line read/write requests (pmem_read/pmem_write, 32-bit address, 256-bit line) and returns a one-cycle resp.
- Converts each request into a 4-beat, 64-bit burst transaction on the external memory interface.
- Sits between the cache controller/datapath and main memory.

Parameters:
- s_offset, 5, byte-offset bits of a line address
- s_line, 256, cache line width in bits
- s_burst, 64, burst beat width in bits
- n_beats, s_line/s_burst (=4), beats per line, localparam; s_line must divide evenly

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pmem_address  in  32  line address from cache
- pmem_read  in  1  line read request; held until pmem_resp
- pmem_write  in  1  line write request; held until pmem_resp
- pmem_wdata  in  s_line  line to write
- pmem_rdata  out  s_line  assembled read line
- pmem_resp  out  1  one-cycle completion pulse to cache
- mem_address  out  32  burst address, line-aligned
- mem_read  out  1  burst read request
- mem_write  out  1  burst write request
- mem_wdata  out  s_burst  current write beat
- mem_rdata  in  s_burst  read beat
- mem_resp  in  1  beat accepted/valid

Behaviour:
- States: IDLE, READ, WRITE, DONE. Beat counter cnt is 2 bits, range 0..n_beats-1.
- Reset: state=IDLE, cnt=0, and pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata all 0.
- Reset mid-burst: abort. mem_read/mem_write are low the cycle after rst is sampled, and no pmem_resp is issued.
- IDLE:
  - pmem_write=1 -> WRITE. Latch pmem_wdata into the line buffer and pmem_address with low s_offset bits forced to 0. cnt=0.
  - Else pmem_read=1 -> READ, same address latch.
  - Both high: write has priority; the read is served after the cache re-requests.
- READ:
  - mem_read=1 and mem_address=latched address, held constant for the whole burst.
  - Each cycle with mem_resp=1: buffer[cnt*64 +: 64] <= mem_rdata, cnt++.
  - Gaps (mem_resp=0) are allowed; the state holds.
  - On the beat where cnt==n_beats-1 -> DONE. mem_read drops on entry to DONE.
- WRITE:
  - mem_write=1, mem_wdata = buffer[cnt*64 +: 64] (combinational from cnt).
  - Each mem_resp=1 advances cnt. On the last beat -> DONE.
- Beat order: beat 0 = bits [63:0] first, ascending.
- DONE:
  - pmem_resp=1 for exactly one cycle, then IDLE.
  - Read: pmem_rdata is updated from the buffer on entry to DONE and held stable until the next read completes.
  - Write: pmem_rdata is unchanged.
- Latency: with zero-gap memory (mem_resp=1 every cycle that mem_read/mem_write is high), pmem_resp rises exactly 5 cycles after the request is sampled in IDLE. The 4 burst cycles start the cycle after acceptance.
- pmem_read, pmem_write, pmem_address and pmem_wdata changes after acceptance are ignored; only latched values are used.
- mem_resp in IDLE/DONE is ignored.
- A request still high in the cycle after DONE is treated as new. The cache drops its request the cycle after pmem_resp.
- cnt wraps to 0 after the last beat.

Decomposition:
- Shared package cache_types: line_t (logic[255:0]), burst_t (logic[63:0]), constants S_OFFSET=5 and N_BEATS=4, and the adaptor state enum.
- No sub-module; counter and buffer stay inline.

Test Plan:
- Read, zero-gap: pmem_read=1, addr 0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_address=0x0000_1220; pmem_resp on cycle 5 for exactly 1 cycle; pmem_rdata = {44..,33..,22..,11..}.
- Write: pmem_write=1, wdata = {D,C,B,A} 64-bit words, memory acks with 2-cycle gaps -> mem_wdata=A,B,C,D in order, each held until its mem_resp; one pmem_resp after the 4th ack.
- Read and write asserted together in IDLE -> WRITE taken (mem_write=1, mem_read=0).
- Back-to-back: write, then read issued the cycle after pmem_resp -> read accepted; no lost or duplicated beats; pmem_rdata unchanged between the two.
- rst asserted after beat 2 of a read -> next cycle mem_read=0, state IDLE, no pmem_resp; a new read then completes correctly from beat 0.
- mem_resp pulses while IDLE -> no state change, pmem_rdata unchanged.
